// File: rtl/video_pkg.sv
// video_pkg: shared widths, config addresses and mode encoding for the pixel shifter
package video_pkg;
    localparam int COLOR_W = 6;
    localparam logic [1:0] CFG_FG = 2'd0;
    localparam logic [1:0] CFG_BG = 2'd1;
    localparam logic [1:0] CFG_MODE = 2'd2;
    typedef enum logic {MODE_COLOR = 1'b0, MODE_MONO = 1'b1} mode_t;
    function automatic logic [COLOR_W-1:0] dim_rgb(input logic [COLOR_W-1:0] c);
        return {1'b0, c[5], 1'b0, c[3], 1'b0, c[1]};
    endfunction
endpackage

// File: rtl/video_sync_delay.sv
// video_sync_delay: DEPTH-stage delay line for {visible, hsync, vsync}
// Ports: master_clock (rising edge), reset (async, active-low),
//        line_sigs = {visible, hsync_n, vsync_n} in, delayed_sigs out.
// Reset value {0, 1, 1}: blanked with both syncs inactive. DEPTH = 0 is a wire.
module video_sync_delay #(
    parameter int DEPTH = 1
) (
    input  logic       master_clock,
    input  logic       reset,
    input  logic [2:0] line_sigs,
    output logic [2:0] delayed_sigs
);
    if (DEPTH == 0) begin : g_bypass
        assign delayed_sigs = line_sigs;
    end else begin : g_pipe
        logic [2:0] stage [DEPTH];
        always_ff @(posedge master_clock or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= 3'b011;
            end else begin
                stage[0] <= line_sigs;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end
        assign delayed_sigs = stage[DEPTH-1];
    end
endmodule

// File: rtl/video_pixel_shifter.sv
// video_pixel_shifter: turns RAM bytes into 6-bit RGB pixels with aligned, delayed syncs
// Ports: master_clock, reset (async, active-low), phi2, data[7:0], visible,
//        hsync_in/vsync_in (active-low), cfg_we, cfg_addr[1:0], cfg_data[5:0] in;
//        red/green/blue[1:0], hsync_out/vsync_out (active-low) out.
// Optional: define SCANLINE_DIM_EN to halve channel intensity on odd scanlines.
module video_pixel_shifter
    import video_pkg::*;
#(
    parameter int                 SYNC_DELAY = 1,
    parameter logic [COLOR_W-1:0] FG_RESET   = 6'h3F,
    parameter logic [COLOR_W-1:0] BG_RESET   = 6'h00
) (
    input  logic               master_clock,
    input  logic               reset,
    input  logic               phi2,
    input  logic [7:0]         data,
    input  logic               visible,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [COLOR_W-1:0] cfg_data,
    output logic [1:0]         red,
    output logic [1:0]         green,
    output logic [1:0]         blue,
    output logic               hsync_out,
    output logic               vsync_out
);
    logic [7:0] hold_reg, pix_reg;
    logic phase, pix_bit, vis_d, mode_wr;
    logic [2:0] sync_cap, sync_dly;
    logic [COLOR_W-1:0] fg, bg, pix_rgb, rgb;
    mode_t mode, mode_pend, mode_sel;

    // phi2 low edges capture (and enter phase 1 of the previous byte); phi2 high edges load.
    always_ff @(posedge master_clock or negedge reset) begin
        if (!reset) begin
            hold_reg <= '0;
            pix_reg  <= '0;
            phase    <= 1'b0;
            sync_cap <= 3'b011;
        end else if (!phi2) begin
            hold_reg <= data;
            sync_cap <= {visible, hsync_in, vsync_in};
            phase    <= 1'b1;
        end else begin
            pix_reg  <= hold_reg;
            phase    <= 1'b0;
        end
    end

    video_sync_delay #(.DEPTH(SYNC_DELAY)) u_sync_delay (
        .master_clock (master_clock),
        .reset        (reset),
        .line_sigs    (sync_cap),
        .delayed_sigs (sync_dly)
    );

    // Mode changes are staged and only applied on a load edge so a pixel never switches mode halfway.
    assign mode_wr  = cfg_we && cfg_addr == CFG_MODE;
    assign mode_sel = mode_wr ? mode_t'(cfg_data[0]) : mode_pend;

    always_ff @(posedge master_clock or negedge reset) begin
        if (!reset) begin
            fg        <= FG_RESET;
            bg        <= BG_RESET;
            mode      <= MODE_COLOR;
            mode_pend <= MODE_COLOR;
        end else begin
            if (cfg_we && cfg_addr == CFG_FG) fg <= cfg_data;
            if (cfg_we && cfg_addr == CFG_BG) bg <= cfg_data;
            if (mode_wr) mode_pend <= mode_t'(cfg_data[0]);
            if (phi2) mode <= mode_sel;
        end
    end

    assign vis_d     = sync_dly[2];
    assign hsync_out = sync_dly[1];
    assign vsync_out = sync_dly[0];
    assign pix_bit   = phase ? pix_reg[6] : pix_reg[7];
    assign pix_rgb   = (mode == MODE_MONO) ? (pix_bit ? fg : bg) : pix_reg[5:0];

`ifdef SCANLINE_DIM_EN
    logic hs_prev, line_odd;
    always_ff @(posedge master_clock or negedge reset) begin
        if (!reset) begin
            hs_prev  <= 1'b1;
            line_odd <= 1'b0;
        end else begin
            hs_prev  <= hsync_out;
            line_odd <= !vsync_out ? 1'b0 : (hs_prev && !hsync_out) ? !line_odd : line_odd;
        end
    end
    assign rgb = !vis_d ? '0 : line_odd ? dim_rgb(pix_rgb) : pix_rgb;
`else
    assign rgb = vis_d ? pix_rgb : '0;
`endif

    assign {red, green, blue} = rgb;
endmodule

// File: tb/tb_video_pixel_shifter.sv
// tb_video_pixel_shifter: directed table-driven bench for video_pixel_shifter
module tb_video_pixel_shifter;
    import video_pkg::*;

    logic master_clock, reset, phi2, visible, hsync_in, vsync_in, cfg_we;
    logic [7:0] data;
    logic [1:0] cfg_addr, red, green, blue;
    logic [5:0] cfg_data;
    logic hsync_out, vsync_out;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic       vis, hs, vs;
        logic [5:0] e0, e1;
    } vec_t;
    vec_t vec [17];

`ifdef SCANLINE_DIM_EN
    localparam logic [5:0] DIM = 6'h15;
`else
    localparam logic [5:0] DIM = 6'h3F;
`endif

    video_pixel_shifter dut (
        .master_clock (master_clock),
        .reset        (reset),
        .phi2         (phi2),
        .data         (data),
        .visible      (visible),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out)
    );

    initial begin
        master_clock = 0;
        forever #5 master_clock = ~master_clock;
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic chk_px(input int i, input logic [5:0] e);
        chk($sformatf("rgb[%0d]", i), {2'b0, red, green, blue}, {2'b0, e});
        chk($sformatf("hsync[%0d]", i), {7'b0, hsync_out}, {7'b0, vec[i].hs});
        chk($sformatf("vsync[%0d]", i), {7'b0, vsync_out}, {7'b0, vec[i].vs});
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi + 1; i++) begin
            @(negedge master_clock);
            phi2 = 0;
            if (i <= hi) begin
                data = vec[i].d; visible = vec[i].vis; hsync_in = vec[i].hs; vsync_in = vec[i].vs;
            end else begin
                data = 8'h00; visible = 0; hsync_in = 1; vsync_in = 1;
            end
            @(posedge master_clock); #1;
            if (i > lo) chk_px(i - 1, vec[i-1].e1);
            if (i <= hi) begin
                @(negedge master_clock);
                phi2 = 1;
                @(posedge master_clock); #1;
                chk_px(i, vec[i].e0);
            end
        end
    endtask

    task automatic cfg(input logic [1:0] a, input logic [5:0] v);
        @(negedge master_clock);
        phi2 = 0; visible = 0; cfg_we = 1; cfg_addr = a; cfg_data = v;
        @(negedge master_clock);
        phi2 = 1; cfg_we = 0;
    endtask

    initial begin
        vec[0]  = '{8'hE4, 1, 1, 1, 6'h24, 6'h24};
        vec[1]  = '{8'h3F, 1, 1, 1, 6'h3F, 6'h3F};
        vec[2]  = '{8'hC0, 1, 1, 1, 6'h00, 6'h00};
        vec[3]  = '{8'h15, 1, 1, 1, 6'h15, 6'h15};
        vec[4]  = '{8'hFF, 0, 0, 0, 6'h00, 6'h00};
        vec[5]  = '{8'h3F, 1, 1, 1, 6'h3F, 6'h3F};
        vec[6]  = '{8'h00, 0, 0, 1, 6'h00, 6'h00};
        vec[7]  = '{8'h3F, 1, 1, 1, DIM,   DIM  };
        vec[8]  = '{8'h00, 0, 1, 0, 6'h00, 6'h00};
        vec[9]  = '{8'h3F, 1, 1, 1, 6'h3F, 6'h3F};
        vec[10] = '{8'h80, 1, 1, 1, 6'h30, 6'h03};
        vec[11] = '{8'h40, 1, 1, 1, 6'h03, 6'h30};
        vec[12] = '{8'hC0, 1, 1, 1, 6'h30, 6'h30};
        vec[13] = '{8'h3F, 1, 1, 1, 6'h03, 6'h03};
        vec[14] = '{8'h80, 1, 1, 1, 6'h0C, 6'h03};
        vec[15] = '{8'hE4, 1, 1, 1, 6'h24, 6'h24};
        vec[16] = '{8'h80, 1, 1, 1, 6'h3F, 6'h00};

        reset = 0; phi2 = 1; data = 8'hFF; visible = 0; hsync_in = 1; vsync_in = 1;
        cfg_we = 0; cfg_addr = 0; cfg_data = 0;
        repeat (3) @(posedge master_clock);
        #1;
        chk("reset_rgb", {2'b0, red, green, blue}, 8'h00);
        chk("reset_hsync", {7'b0, hsync_out}, 8'h01);
        chk("reset_vsync", {7'b0, vsync_out}, 8'h01);
        @(negedge master_clock) reset = 1;
        repeat (6) @(posedge master_clock);
        #1;
        chk("boot_rgb", {2'b0, red, green, blue}, 8'h00);
        chk("boot_hsync", {7'b0, hsync_out}, 8'h01);

        run(0, 9);

        cfg(CFG_FG, 6'h30);
        cfg(CFG_BG, 6'h03);
        cfg(CFG_MODE, 6'h01);
        run(10, 13);

        @(negedge master_clock);
        phi2 = 0; data = 8'hC0; visible = 1; hsync_in = 1; vsync_in = 1;
        @(negedge master_clock);
        phi2 = 1;
        @(posedge master_clock); #1;
        chk("race_p0", {2'b0, red, green, blue}, 8'h30);
        @(negedge master_clock);
        phi2 = 0; data = 8'h00; visible = 0; cfg_we = 1; cfg_addr = CFG_FG; cfg_data = 6'h0C;
        @(posedge master_clock); #1;
        chk("race_p1", {2'b0, red, green, blue}, 8'h0C);
        @(negedge master_clock);
        phi2 = 1; cfg_we = 0;

        cfg(2'd3, 6'h00);
        run(14, 14);

        @(negedge master_clock);
        phi2 = 0; data = 8'hFF; visible = 1; hsync_in = 0; vsync_in = 0;
        @(negedge master_clock);
        phi2 = 1;
        @(posedge master_clock); #1;
        chk("midrst_p0", {2'b0, red, green, blue}, 8'h0C);
        chk("midrst_hsync_lo", {7'b0, hsync_out}, 8'h00);
        @(negedge master_clock);
        phi2 = 0; data = 8'h00; visible = 0; hsync_in = 1; vsync_in = 1;
        @(posedge master_clock); #1;
        chk("midrst_p1", {2'b0, red, green, blue}, 8'h0C);
        #1 reset = 0;
        #1;
        chk("midrst_rgb", {2'b0, red, green, blue}, 8'h00);
        chk("midrst_hsync", {7'b0, hsync_out}, 8'h01);
        chk("midrst_vsync", {7'b0, vsync_out}, 8'h01);
        @(negedge master_clock) reset = 1;

        run(15, 15);
        cfg(CFG_MODE, 6'h01);
        run(16, 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
